// File: rtl/btn_input_ctrl_if.sv
// Button controller bus: raw button levels in, debounced levels and event pulses out.
// dbg_state carries each channel's FSM state (2 bits per channel, channel 0 in the LSBs).
interface btn_input_ctrl_if #(
    parameter int NUM_BTN = 5
);
    logic [NUM_BTN-1:0]   btn_in;
    logic [NUM_BTN-1:0]   btn_level;
    logic [NUM_BTN-1:0]   btn_press;
    logic [NUM_BTN-1:0]   btn_release;
    logic [NUM_BTN-1:0]   btn_long;
    logic                 any_press;
    logic [2*NUM_BTN-1:0] dbg_state;

    modport master (
        output btn_in,
        input  btn_level, btn_press, btn_release, btn_long, any_press, dbg_state
    );

    modport slave (
        input  btn_in,
        output btn_level, btn_press, btn_release, btn_long, any_press, dbg_state
    );
endinterface

// File: rtl/btn_input_ctrl.sv
// Multi-channel push-button conditioner: synchronizes, debounces and detects
// press, release and long-press events independently on every channel.
module btn_input_ctrl #(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int NUM_BTN       = 5,
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 1000
) (
    input logic             clk,
    input logic             rst_n,
    btn_input_ctrl_if.slave bus
);
    localparam int DEB_CYC  = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYC = CLK_FREQ / 1000 * LONG_PRESS_MS;
    localparam int DEB_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int HOLD_W   = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        HELD      = 2'd2,
        REL_DEB   = 2'd3
    } state_e;

    logic [NUM_BTN-1:0] meta_q;
    logic [NUM_BTN-1:0] sync_q;
    logic [NUM_BTN-1:0] press_set;
    logic               any_press_q;

    // Two-flop synchronizer; nothing downstream looks at btn_in directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= bus.btn_in;
            sync_q <= meta_q;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        state_e             state_q;
        logic [DEB_W-1:0]   deb_cnt_q;
        logic [HOLD_W-1:0]  hold_cnt_q;
        logic               long_done_q;
        logic               level_q;
        logic               press_q;
        logic               release_q;
        logic               long_q;

        // Shared with the any_press register so both pulses land on the same edge.
        assign press_set[g] = (state_q == PRESS_DEB) && sync_q[g] && (deb_cnt_q == DEB_MAX);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q     <= IDLE;
                deb_cnt_q   <= '0;
                hold_cnt_q  <= '0;
                long_done_q <= 1'b0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                long_q      <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (sync_q[g]) begin
                            state_q   <= PRESS_DEB;
                            deb_cnt_q <= '0;
                        end
                    end
                    PRESS_DEB: begin
                        if (!sync_q[g]) begin
                            state_q <= IDLE;
                        end else if (press_set[g]) begin
                            state_q     <= HELD;
                            level_q     <= 1'b1;
                            press_q     <= 1'b1;
                            hold_cnt_q  <= '0;
                            long_done_q <= 1'b0;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!sync_q[g]) begin
                            state_q   <= REL_DEB;
                            deb_cnt_q <= '0;
                        end else if (hold_cnt_q == HOLD_MAX) begin
                            // Counter parks at its terminal value; long_done keeps the pulse single.
                            if (!long_done_q) begin
                                long_q      <= 1'b1;
                                long_done_q <= 1'b1;
                            end
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                    REL_DEB: begin
                        // hold_cnt and long_done are frozen here so a release glitch resumes the hold.
                        if (sync_q[g]) begin
                            state_q <= HELD;
                        end else if (deb_cnt_q == DEB_MAX) begin
                            state_q   <= IDLE;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign bus.btn_level[g]          = level_q;
        assign bus.btn_press[g]          = press_q;
        assign bus.btn_release[g]        = release_q;
        assign bus.btn_long[g]           = long_q;
        assign bus.dbg_state[2*g +: 2]   = state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_set;
        end
    end

    assign bus.any_press = any_press_q;

endmodule

// File: doc/btn_input_ctrl.md
BTN_INPUT_CTRL -- requirements
Module: btn_input_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, clock frequency in Hz.
REQ-002 Parameter NUM_BTN, default 5, number of independent push-button channels.
REQ-003 Parameter DEBOUNCE_MS, default 20, required input stability time in ms.
REQ-004 Parameter LONG_PRESS_MS, default 1000, hold time in ms before a long-press event.
REQ-005 Derived constants SHALL be DEB_CYC = CLK_FREQ/1000*DEBOUNCE_MS and LONG_CYC = CLK_FREQ/1000*LONG_PRESS_MS; both SHALL be >= 1.
REQ-006 Port clk, input, 1, system clock; single clock domain.
REQ-007 Port rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port btn_in, input, NUM_BTN, raw asynchronous button levels, active-high, bouncing.
REQ-009 Port btn_level, output, NUM_BTN, debounced button level.
REQ-010 Port btn_press, output, NUM_BTN, 1-cycle pulse on each debounced press.
REQ-011 Port btn_release, output, NUM_BTN, 1-cycle pulse on each debounced release.
REQ-012 Port btn_long, output, NUM_BTN, 1-cycle pulse, at most once per press, when a hold reaches LONG_CYC.
REQ-013 Port any_press, output, 1, OR of all btn_press bits in the same cycle.

Function
REQ-014 Each btn_in bit SHALL pass through a 2-flop synchronizer before any use.
REQ-015 Each channel SHALL have an independent FSM with states IDLE, PRESS_DEB, HELD and REL_DEB, plus a debounce counter, a hold counter and a long_done flag.
REQ-016 IDLE: sync=1 -> PRESS_DEB, deb_cnt=0.
REQ-017 PRESS_DEB: sync=0 -> IDLE with no event; deb_cnt==DEB_CYC-1 -> HELD, btn_level=1, btn_press pulse, hold_cnt=0, long_done=0; otherwise deb_cnt+1.
REQ-018 HELD: sync=0 -> REL_DEB, deb_cnt=0; otherwise, if hold_cnt==LONG_CYC-1 and !long_done, a btn_long pulse and long_done=1; otherwise hold_cnt+1, saturating at LONG_CYC-1.
REQ-019 REL_DEB: sync=1 -> HELD with hold_cnt and long_done preserved; deb_cnt==DEB_CYC-1 -> IDLE, btn_level=0, btn_release pulse; otherwise deb_cnt+1.
REQ-020 hold_cnt SHALL NOT advance in REL_DEB.
REQ-021 All outputs SHALL be registered.
REQ-022 Pulse outputs SHALL be high for exactly one cycle per event.
REQ-023 Latency: with stable input, btn_press SHALL be high after the (DEB_CYC+2)th clock edge following the edge that first samples btn_in high; btn_release latency SHALL be identical for a release.
REQ-024 btn_long SHALL be high after edge DEB_CYC+2+LONG_CYC, counted from the same first-sampling edge.
REQ-025 Any glitch shorter than DEB_CYC synchronized cycles SHALL produce no event and no btn_level change.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-027 btn_press and btn_release SHALL never be high in the same cycle on one channel.
REQ-028 btn_long SHALL never fire outside HELD.
REQ-029 Counter widths SHALL be $clog2 of their terminal values, minimum 1 bit, with no wrap-around.

Reset
REQ-030 rst_n low SHALL immediately force every FSM to IDLE, clear synchronizers, counters and long_done, and drive all outputs to 0.
REQ-031 Reset asserted mid-press SHALL drop btn_level with no btn_release pulse.
REQ-032 A button held through reset release SHALL be treated as a new press, producing btn_press after DEB_CYC+2 edges.

Verification (bench parameters: CLK_FREQ=10_000, NUM_BTN=5, DEBOUNCE_MS=2 -> DEB_CYC=20, LONG_PRESS_MS=10 -> LONG_CYC=100)
REQ-033 Clean press, btn_in[0]=1 held 60 cycles then 0 -> btn_press[0] after edge 22, btn_level[0]=1 from edge 22, btn_release[0] 22 edges after the fall, no btn_long.
REQ-034 Bounce, btn_in[1] toggled every 5 cycles for 50 cycles then held 1 -> no event during toggling; exactly one btn_press[1], 22 edges after the final rise.
REQ-035 Long press, btn_in[2]=1 held 300 cycles -> btn_press[2] at edge 22, exactly one btn_long[2] at edge 122, single btn_release after the fall.
REQ-036 Release glitch, btn_in[2] held 200 cycles, then 0 for 10 cycles, then 1 -> btn_level stays 1, no release, no second btn_press or btn_long.
REQ-037 Simultaneous press, btn_in[4:0]=5'b11111 at one edge -> btn_press=5'b11111 and any_press=1 in the same single cycle.
REQ-038 Reset mid-hold, btn_in[3]=1, rst_n pulsed low at cycle 50 and btn kept high -> outputs 0 during reset, no release pulse, new btn_press[3] 22 edges after rst_n rises.
